tacho_capture: RTL

- Receive end of the two-channel tachometer interface: decodes a speed pulse pair (ch1/ch2, quadrature-style) driven by the tachometer generator.
- Measures ch1 period and ch1→ch2 phase in I_clk cycles, derives direction, and keeps an up/down pulse count.
- Sits on the input-capture side of the board, with results read by the host register block.

---
 rtl/tacho_capture.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tacho_capture.sv
// -----------------------------------------------------------------------------
// tacho_capture
//   Receive side of the two-channel tachometer interface. Synchronizes and
//   glitch-filters the ch1/ch2 speed pulses, measures the ch1 period and the
//   ch1->ch2 phase in I_clk cycles, derives rotation direction and keeps a
//   signed up/down count of ch1 rising edges.
//
// Ports
//   I_clk          system clock (25 MHz)
//   I_reset_n      asynchronous active-low reset
//   I_spd1/I_spd2  asynchronous speed inputs, channel 1 / channel 2
//   I_enable       capture enable (level); low forces IDLE
//   I_load         single-cycle strobe, presets the pulse counter
//   I_init_pulse   pulse counter preset value
//   O_period       clocks between the last two ch1 rises (0 = stalled/unknown)
//   O_phase        clocks from a ch1 rise to the next ch2 rise
//   O_dir          0 = ch1 leads, 1 = ch2 leads
//   O_pulse_cnt    signed up/down ch1 edge count (modulo 2^32)
//   O_valid        one-cycle pulse whenever O_period is written
//   O_stalled      no ch1 rise seen for TIMEOUT clocks
// -----------------------------------------------------------------------------
module tacho_capture #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned TIMEOUT  = 25000000
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_spd1,
  input  logic        I_spd2,
  input  logic        I_enable,
  input  logic        I_load,
  input  logic [31:0] I_init_pulse,
  output logic [31:0] O_period,
  output logic [31:0] O_phase,
  output logic        O_dir,
  output logic [31:0] O_pulse_cnt,
  output logic        O_valid,
  output logic        O_stalled
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned FLT_W = 4;
  localparam int unsigned NCH   = 2;

  localparam logic [FLT_W-1:0] FILT_LAST = FLT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input path: 2-flop synchronizer, run-length glitch filter, rise strobe.
  // Index 0 is ch1, index 1 is ch2.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0]            meta_q, meta_d;
  logic [NCH-1:0]            sync_q, sync_d;
  logic [NCH-1:0]            filt_q, filt_d;
  logic [NCH-1:0]            rise_q, rise_d;
  logic [NCH-1:0][FLT_W-1:0] fcnt_q, fcnt_d;

  // Filter: the level flips on the FILT_LEN-th consecutive differing sample;
  // the rise strobe is registered alongside so it coincides with the new level.
  always_comb begin
    meta_d = {I_spd2, I_spd1};
    sync_d = meta_q;
    filt_d = filt_q;
    rise_d = '0;
    fcnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sync_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) begin
          filt_d[i] = sync_q[i];
          rise_d[i] = sync_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + FLT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
      filt_q <= '0;
      rise_q <= '0;
      fcnt_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fcnt_q <= fcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement FSM and datapath
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
  logic             win_q, win_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;

  logic r1_c;
  logic r2_c;
  logic timeout_c;

  assign r1_c      = rise_q[0];
  assign r2_c      = rise_q[1];
  assign timeout_c = (per_cnt_q == TO_LAST) && !r1_c;

  // State register
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    ph_cnt_d  = ph_cnt_q;
    win_d     = win_q;
    period_d  = period_q;
    phase_d   = phase_q;
    dir_d     = dir_q;
    pcnt_d    = pcnt_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;

    if (!I_enable) begin
      // Disable overrides everything, including a coincident r1.
      state_d   = ST_IDLE;
      per_cnt_d = '0;
      ph_cnt_d  = '0;
      win_d     = 1'b0;
      stalled_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_ARM;
          per_cnt_d = '0;
          ph_cnt_d  = '0;
          win_d     = 1'b0;
          stalled_d = 1'b0;
        end

        ST_ARM, ST_RUN: begin
          per_cnt_d = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
          if (win_q) begin
            ph_cnt_d = ph_cnt_q + CNT_ONE;
          end

          if (r1_c) begin
            // ch2 already high at a ch1 rise means ch2 leads.
            per_cnt_d = '0;
            dir_d     = filt_q[1];
            pcnt_d    = filt_q[1] ? pcnt_q - CNT_ONE : pcnt_q + CNT_ONE;
            stalled_d = 1'b0;
            state_d   = ST_RUN;
            if (state_q == ST_RUN) begin
              period_d = per_cnt_q + CNT_ONE;
              valid_d  = 1'b1;
            end
            // Open (or restart) the phase window unless ch2 rose together.
            ph_cnt_d = '0;
            if (r2_c) begin
              phase_d = '0;
              win_d   = 1'b0;
            end else begin
              win_d   = 1'b1;
            end
          end else begin
            if (r2_c && win_q) begin
              phase_d = ph_cnt_q + CNT_ONE;
              win_d   = 1'b0;
            end
            if (timeout_c) begin
              period_d  = '0;
              stalled_d = 1'b1;
              valid_d   = 1'b1;
              per_cnt_d = '0;
              win_d     = 1'b0;
              state_d   = ST_ARM;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Preset wins over a coincident edge count, in every state.
    if (I_load) begin
      pcnt_d = I_init_pulse;
    end
  end

  // Datapath registers
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      per_cnt_q <= '0;
      ph_cnt_q  <= '0;
      win_q     <= 1'b0;
      period_q  <= '0;
      phase_q   <= '0;
      dir_q     <= 1'b0;
      pcnt_q    <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      win_q     <= win_d;
      period_q  <= period_d;
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      pcnt_q    <= pcnt_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
  end

  assign O_period    = period_q;
  assign O_phase     = phase_q;
  assign O_dir       = dir_q;
  assign O_pulse_cnt = pcnt_q;
  assign O_valid     = valid_q;
  assign O_stalled   = stalled_q;

endmodule
